// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package cpu_fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP
  } next_pc_sel_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode redirect/stall inputs, imem data, PC and IF/ID outputs.
interface fetch_stage_if;

  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_fault;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_index, instr_in,
    input  pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_fault
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_index, instr_in,
    output pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_fault
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC computation: jump beats branch beats sequential.
module fetch_next_pc
  import cpu_fetch_pkg::*;
(
  input  logic [31:0]  pc,
  input  logic [31:0]  ifid_pc4,
  input  logic         ifid_valid,
  input  logic         jump,
  input  logic [25:0]  jump_index,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  output logic [31:0]  pc_plus4,
  output logic [31:0]  next_pc,
  output next_pc_sel_t sel
);

  logic unused_bits;
  assign unused_bits = ^{branch_target[1:0], ifid_pc4[27:0]};

  assign pc_plus4 = pc + 32'(WORD_BYTES);

  // A bubble in IF/ID cannot own a redirect, so gate with its valid bit.
  always_comb begin
    sel = SEL_SEQ;
    if (ifid_valid) begin
      if (jump)
        sel = SEL_JUMP;
      else if (branch_taken)
        sel = SEL_BRANCH;
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_JUMP:   next_pc = {ifid_pc4[31:28], jump_index, 2'b00};
      SEL_BRANCH: next_pc = {branch_target[31:2], 2'b00};
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register and sticky fetch fault.
// Define FETCH_DELAY_SLOT_EN to keep the instruction after a redirect (MIPS delay slot).
module fetch_stage
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  localparam logic [32:0] PC_LIMIT = 33'(WORD_BYTES * IMEM_WORDS);

  logic [31:0]  pc_reg;
  ifid_t        ifid_reg;
  logic         fault_reg;
  logic [31:0]  next_pc;
  logic [31:0]  pc_plus4;
  next_pc_sel_t sel;
  logic         out_of_range;
  logic         flush_ifid;

  fetch_next_pc u_next_pc (
    .pc            (pc_reg),
    .ifid_pc4      (ifid_reg.pc4),
    .ifid_valid    (ifid_reg.valid),
    .jump          (bus.jump),
    .jump_index    (bus.jump_index),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .sel           (sel)
  );

  assign out_of_range = ({1'b0, pc_reg} >= PC_LIMIT);

`ifdef FETCH_DELAY_SLOT_EN
  logic unused_sel;
  assign unused_sel = ^sel;
  assign flush_ifid = 1'b0;
`else
  assign flush_ifid = (sel != SEL_SEQ);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      ifid_reg  <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
      fault_reg <= 1'b0;
    end else if (fault_reg) begin
      ifid_reg.valid <= 1'b0;
    end else if (!bus.stall) begin
      if (out_of_range) begin
        // Faulting fetch: PC parks on the bad address for the debugger.
        fault_reg      <= 1'b1;
        ifid_reg.valid <= 1'b0;
      end else begin
        pc_reg <= next_pc;
        if (flush_ifid)
          ifid_reg <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
        else
          ifid_reg <= '{instr: bus.instr_in, pc4: pc_plus4, valid: 1'b1};
      end
    end
  end

  assign bus.pc_out      = pc_reg;
  assign bus.ifid_instr  = ifid_reg.instr;
  assign bus.ifid_pc4    = ifid_reg.pc4;
  assign bus.ifid_valid  = ifid_reg.valid;
  assign bus.fetch_fault = fault_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned IMEM_WORDS = 1024;

  logic clk = 1'b0;
  logic reset;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:IMEM_WORDS-1];
  assign bus.instr_in = (bus.pc_out < 32'(4 * IMEM_WORDS)) ? mem[bus.pc_out[11:2]] : 32'hDEAD_BEEF;

  // Reference state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_fault;
  int checks = 0;
  int passed = 0;

  function automatic logic [97:0] act_vec();
    return {bus.pc_out, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid, bus.fetch_fault};
  endfunction

  function automatic logic [97:0] exp_vec();
    return {m_pc, m_instr, m_pc4, m_valid, m_fault};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
  endtask

  // One clock edge of the fetch rules, evaluated from the inputs presented now.
  task automatic model_edge();
    bit          redirect;
    logic [31:0] tgt;
    redirect = m_valid && (bus.jump || bus.branch_taken);
    if (bus.jump)
      tgt = (m_pc4 & 32'hF000_0000) | (32'(bus.jump_index) * 4);
    else
      tgt = bus.branch_target & ~32'd3;
    if (m_fault) begin
      m_valid = 0;
    end else if (bus.stall) begin
      // everything holds
    end else if (m_pc >= 32'(4 * IMEM_WORDS)) begin
      m_fault = 1;
      m_valid = 0;
    end else if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
      m_instr = mem[m_pc / 4];
      m_pc4   = m_pc + 4;
      m_valid = 1;
`else
      m_instr = 0;
      m_pc4   = 0;
      m_valid = 0;
`endif
      m_pc = tgt;
    end else begin
      m_instr = mem[m_pc / 4];
      m_pc4   = m_pc + 4;
      m_valid = 1;
      m_pc    = m_pc + 4;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump = 0; bus.jump_index = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (act_vec() !== 98'h0) $display("FAIL reset_state got %h want %h", act_vec(), 98'h0);
    else passed++;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.pc_out !== 32'(4 * (i + 1)) || bus.ifid_instr !== mem[i] ||
          bus.ifid_pc4 !== 32'(4 * (i + 1)) || bus.ifid_valid !== 1'b1)
        $display("FAIL seq_step%0d got pc=%h instr=%h pc4=%h v=%b want pc=%h instr=%h pc4=%h v=1",
                 i, bus.pc_out, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid,
                 32'(4 * (i + 1)), mem[i], 32'(4 * (i + 1)));
      else passed++;
    end
  endtask

  task automatic test_branch();
    bus.branch_taken = 1; bus.branch_target = 32'h40;
    tick();
    clear_inputs();
    checks++;
`ifdef FETCH_DELAY_SLOT_EN
    if (bus.pc_out !== 32'h40 || bus.ifid_valid !== 1'b1 || bus.ifid_instr !== mem[4] || bus.ifid_pc4 !== 32'h14)
      $display("FAIL branch_slot got pc=%h instr=%h pc4=%h v=%b want pc=40 instr=%h pc4=14 v=1",
               bus.pc_out, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid, mem[4]);
`else
    if (bus.pc_out !== 32'h40 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0 || bus.ifid_pc4 !== 32'h0)
      $display("FAIL branch_flush got pc=%h instr=%h pc4=%h v=%b want pc=40 instr=0 pc4=0 v=0",
               bus.pc_out, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid);
`endif
    else passed++;
    tick();
    checks++;
    if (bus.ifid_instr !== mem[16] || bus.ifid_pc4 !== 32'h44 || bus.ifid_valid !== 1'b1 || bus.pc_out !== 32'h44)
      $display("FAIL branch_target_fetch got pc=%h instr=%h pc4=%h v=%b want pc=44 instr=%h pc4=44 v=1",
               bus.pc_out, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid, mem[16]);
    else passed++;
  endtask

  task automatic test_jump_priority();
    do_reset();
    tick(); tick();
    bus.jump = 1; bus.jump_index = 26'h10; bus.branch_taken = 1; bus.branch_target = 32'h80;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc_out !== 32'h40) $display("FAIL jump_wins got pc=%h want pc=00000040", bus.pc_out);
    else passed++;
    checks++;
    if (act_vec() !== exp_vec()) $display("FAIL jump_model got %h want %h", act_vec(), exp_vec());
    else passed++;

    do_reset();
    tick(); tick();
    bus.branch_taken = 1; bus.branch_target = 32'h43;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc_out !== 32'h40) $display("FAIL branch_align got pc=%h want pc=00000040", bus.pc_out);
    else passed++;
  endtask

  task automatic test_stall();
    logic [97:0] held;
    do_reset();
    tick(); tick(); tick();
    held = act_vec();
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_vec() !== held || act_vec() !== exp_vec())
        $display("FAIL stall_hold%0d got %h want %h", i, act_vec(), held);
      else passed++;
    end
    bus.stall = 0;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc_out !== 32'h100) $display("FAIL stall_release got pc=%h want pc=00000100", bus.pc_out);
    else passed++;
  endtask

  task automatic test_fault();
    do_reset();
    tick(); tick();
    bus.branch_taken = 1; bus.branch_target = 32'h1000;
    tick();
    clear_inputs();
    checks++;
    if (bus.pc_out !== 32'h1000 || bus.fetch_fault !== 1'b0)
      $display("FAIL fault_branch got pc=%h fault=%b want pc=00001000 fault=0", bus.pc_out, bus.fetch_fault);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin bus.branch_taken = 1; bus.branch_target = 32'h8; end
      tick();
      checks++;
      if (bus.pc_out !== 32'h1000 || bus.fetch_fault !== 1'b1 || bus.ifid_valid !== 1'b0 ||
          act_vec() !== exp_vec())
        $display("FAIL fault_sticky%0d got pc=%h fault=%b v=%b want pc=00001000 fault=1 v=0",
                 i, bus.pc_out, bus.fetch_fault, bus.ifid_valid);
      else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    // Enters still faulted from the previous scenario.
    #2;
    reset = 1;
    #1;
    checks++;
    if (bus.pc_out !== 32'h0 || bus.ifid_valid !== 1'b0 || bus.fetch_fault !== 1'b0)
      $display("FAIL async_reset got pc=%h v=%b fault=%b want pc=0 v=0 fault=0",
               bus.pc_out, bus.ifid_valid, bus.fetch_fault);
    else passed++;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    tick(); tick(); tick();
    bus.branch_taken = 1; bus.branch_target = 32'h200;
    #2;
    reset = 1;
    #1;
    checks++;
    if (act_vec() !== 98'h0) $display("FAIL async_reset_redirect got %h want %h", act_vec(), 98'h0);
    else passed++;
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    tick();
    checks++;
    if (bus.pc_out !== 32'h4 || bus.ifid_instr !== mem[0] || bus.ifid_valid !== 1'b1)
      $display("FAIL post_reset_fetch got pc=%h instr=%h v=%b want pc=4 instr=%h v=1",
               bus.pc_out, bus.ifid_instr, bus.ifid_valid, mem[0]);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.branch_taken  = ($urandom_range(0, 4) == 0);
      bus.branch_target = 32'($urandom_range(0, 511)) * 4 + 32'($urandom_range(0, 3));
      bus.jump          = ($urandom_range(0, 9) == 0);
      bus.jump_index    = 26'($urandom_range(0, 511));
      tick();
      checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL random%0d got %h want %h", i, act_vec(), exp_vec());
      else passed++;
    end
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
    reset = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_stall();
    test_random();
    test_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the lab CPU.
- Holds the program counter and drives the instruction memory address.
- Captures the returned instruction into the IF/ID pipeline register consumed by decode.
- Handles sequential fetch, decode-stage redirects (branch/jump), stalls, and out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; byte addresses at or above 4*IMEM_WORDS are out of range.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit hold request; freezes PC and IF/ID.
- branch_taken  in  1  decode resolved a taken branch for the instruction in IF/ID.
- branch_target  in  32  byte address of the branch target; bits [1:0] ignored.
- jump  in  1  decode holds a J-type jump.
- jump_index  in  26  jump instruction index field.
- instr_in  in  32  instruction word from instruction memory for pc_out.
- pc_out  out  32  current PC, the instruction memory address.
- ifid_instr  out  32  latched instruction.
- ifid_pc4  out  32  latched PC+4 of that instruction.
- ifid_valid  out  1  IF/ID holds a real instruction.
- fetch_fault  out  1  sticky out-of-range fetch flag.

Behaviour:
- Reset (async, immediate):
  - pc_out=RESET_PC; ifid_instr=NOP (32'h0); ifid_pc4=0; ifid_valid=0; fetch_fault=0.
- Latency: the instruction at pc_out appears on ifid_* after exactly one rising edge. The memory read is combinational and must settle within the clock period.
- next_pc selection (first match wins):
  - jump: {ifid_pc4[31:28], jump_index, 2'b00}.
  - branch_taken: {branch_target[31:2], 2'b00}.
  - otherwise: pc_out+4, mod 2^32. From 32'hFFFF_FFFC the PC wraps to 0, but that address is out of range anyway.
- Edge update, checked in order:
  - fetch_fault=1: PC and IF/ID hold; ifid_valid forced 0. Cleared only by reset.
  - stall=1: PC and all IF/ID fields hold. Redirect inputs are ignored that cycle; decode re-presents them while IF/ID is held.
  - Redirect (jump or branch_taken) with stall=0: pc_out<=target. IF/ID is flushed (instr=NOP, pc4=0, valid=0), discarding the wrong-path fetch.
  - Normal: pc_out<=pc_out+4; ifid_instr<=instr_in; ifid_pc4<=pc_out+4; ifid_valid<=1.
- Out-of-range fetch: pc_out>=4*IMEM_WORDS with stall=0 on an edge sets fetch_fault=1. That edge does not capture instr_in (valid=0) and the PC holds.
- Redirects are honoured only when ifid_valid=1; with ifid_valid=0 they are treated as 0.
- Reset mid-stall or mid-redirect: reset dominates and all state returns to reset values.

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot. On a redirect edge IF/ID captures instr_in normally (valid=1, pc4=pc_out+4) instead of flushing, and the PC still loads the target.
- Undefined: flush behaviour as above.

Decomposition:
- Package cpu_fetch_pkg:
  - NOP_INSTR=32'h0, WORD_BYTES=4.
  - typedef ifid_t struct {instr, pc4, valid}.
  - enum next_pc_sel_t {SEL_SEQ, SEL_BRANCH, SEL_JUMP}.
- Sub-module fetch_next_pc: combinational target computation and priority select. All registers stay in fetch_stage.

Test Plan:
- Reset, then 4 free-running cycles with memory words 0..3 preloaded:
  - pc_out steps 0,4,8,12,16.
  - ifid_instr equals word0..word3 one cycle later; ifid_pc4 = 4,8,12,16; valid=1.
- Taken branch with branch_target=32'h40 while IF/ID valid:
  - next pc_out=0x40; IF/ID becomes NOP, valid=0; instruction at 0x40 is valid one cycle after.
  - With FETCH_DELAY_SLOT_EN, the slot instruction is captured with valid=1.
- jump=1 and branch_taken=1 together, jump_index=26'h10, ifid_pc4=0x8:
  - pc_out=0x40 (jump wins).
  - Repeat with branch only and branch_target=0x43: pc_out=0x40.
- stall=1 for 3 cycles with branch_taken=1 asserted:
  - pc_out, ifid_* unchanged.
  - Redirect occurs on the first edge after stall drops.
- Branch to 32'h1000 (IMEM_WORDS=1024):
  - fetch_fault=1 after one edge; PC holds 0x1000; ifid_valid=0 persists until reset.
- Async reset asserted between edges mid-stream:
  - pc_out=0, ifid_valid=0, fetch_fault=0 immediately, without waiting for clk.
